riscv_core_div_unit: RTL and testbench

//  RV64M divide front-end: accepts DIV/DIVU/REM/REMU and their W forms from execute via valid/ready.

---
 rtl/riscv_core_div_pkg.sv | 30 +++
 rtl/riscv_core_non_restoring.sv | 61 ++++++
 rtl/riscv_core_div_unit.sv | 121 ++++++++++++
 tb/tb_riscv_core_div_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_div_pkg.sv
// rtl/riscv_core_div_pkg.sv - shared types and operand helpers for the RV64M divide unit
package riscv_core_div_pkg;

  localparam int DIV_XLEN = 64;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RESP,
    S_DRAIN
  } div_state_e;

  // Magnitude of a two's complement value; the most-negative input maps to 2^(XLEN-1) unsigned.
  function automatic logic [DIV_XLEN-1:0] f_abs(input logic [DIV_XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[DIV_XLEN-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [DIV_XLEN-1:0] f_sext32(input logic [DIV_XLEN-1:0] x);
    return {{(DIV_XLEN-32){x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/riscv_core_non_restoring.sv
// rtl/riscv_core_non_restoring.sv - unsigned iterative non-restoring divider, one quotient bit per cycle
module riscv_core_non_restoring #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] step_r;
  logic [XLEN:0]   new_r;
  logic [XLEN:0]   fixed_r;
  logic [XLEN-1:0] new_q;

  // Partial remainder needs two guard bits: |2r + bit| can reach 2*divisor before the add/subtract.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    step_r  = rem_q[XLEN] ? (shifted + {2'b00, divisor}) : (shifted - {2'b00, divisor});
    new_r   = step_r[XLEN:0];
    new_q   = {quo_q[XLEN-2:0], ~step_r[XLEN+1]};
    fixed_r = new_r[XLEN] ? (new_r + {1'b0, divisor}) : new_r;
  end

  // The final iteration is presented combinationally so results appear in the done cycle.
  assign done      = busy_q && (cnt_q == CW'(1));
  assign quotient  = new_q;
  assign remainder = fixed_r[XLEN-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (en) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      cnt_q  <= CW'(XLEN);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= new_r;
      quo_q <= new_q;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_core_div_unit.sv
// rtl/riscv_core_div_unit.sv - RV64M divide front-end: operand prep, core control, sign/word fix-up
module riscv_core_div_unit
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            i_non_restoring_clk,
  input  logic            i_non_restoring_rstn,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [1:0]      i_div_op,
  input  logic            i_div_word,
  input  logic [XLEN-1:0] i_div_rs1,
  input  logic [XLEN-1:0] i_div_rs2,
  input  logic            i_div_flush,
  output logic            o_div_valid,
  input  logic            i_div_ready,
  output logic [XLEN-1:0] o_div_result,
  output logic            o_div_busy
);

  div_state_e      state_q, state_d;
  div_op_e         op_q;
  logic            word_q, neg_q_q, neg_r_q;
  logic [XLEN-1:0] abs_a_q, abs_b_q, result_q;

  logic            is_signed, is_rem, accept, div_zero, overflow;
  logic [XLEN-1:0] a_ext, b_ext, min_neg, special_res;
  logic            core_en, core_done;
  logic [XLEN-1:0] core_quo, core_rem, sel_res, signed_res, final_res;

  always_comb begin
    is_signed = ~i_div_op[0];
    is_rem    = i_div_op[1];
    if (i_div_word) begin
      a_ext   = is_signed ? f_sext32(i_div_rs1) : {{(XLEN-32){1'b0}}, i_div_rs1[31:0]};
      b_ext   = is_signed ? f_sext32(i_div_rs2) : {{(XLEN-32){1'b0}}, i_div_rs2[31:0]};
      min_neg = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext   = i_div_rs1;
      b_ext   = i_div_rs2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    div_zero = (b_ext == '0);
    overflow = is_signed && (a_ext == min_neg) && (b_ext == '1);
    // REMUW returns the sign-extended 32-bit dividend even though the operand was zero-extended.
    if (div_zero) special_res = is_rem ? (i_div_word ? f_sext32(a_ext) : a_ext) : '1;
    else          special_res = is_rem ? '0 : a_ext;
    accept = (state_q == S_IDLE) && i_div_valid && !i_div_flush;
  end

  always_comb begin
    sel_res    = (op_q == OP_REM || op_q == OP_REMU) ? core_rem : core_quo;
    signed_res = ((op_q == OP_REM || op_q == OP_REMU) ? neg_r_q : neg_q_q) ? (~sel_res + 1'b1) : sel_res;
    final_res  = word_q ? f_sext32(signed_res) : signed_res;
  end

  always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
    if (!i_non_restoring_rstn) state_q <= S_IDLE;
    else                       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (div_zero || overflow) ? S_RESP : S_LAUNCH;
      S_LAUNCH: state_d = i_div_flush ? S_DRAIN : S_RUN;
      // A flush landing on the done cycle has nothing left to drain.
      S_RUN: begin
        if (i_div_flush)    state_d = core_done ? S_IDLE : S_DRAIN;
        else if (core_done) state_d = S_RESP;
      end
      S_RESP:   if (i_div_flush || i_div_ready) state_d = S_IDLE;
      S_DRAIN:  if (core_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
    if (!i_non_restoring_rstn) begin
      op_q     <= OP_DIV;
      word_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      abs_a_q  <= '0;
      abs_b_q  <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= div_op_e'(i_div_op);
        word_q  <= i_div_word;
        abs_a_q <= f_abs(a_ext, is_signed);
        abs_b_q <= f_abs(b_ext, is_signed);
        neg_q_q <= is_signed && (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
        neg_r_q <= is_signed && a_ext[XLEN-1];
        if (div_zero || overflow) result_q <= special_res;
      end
      if (state_q == S_RUN && core_done && !i_div_flush) result_q <= final_res;
    end
  end

  assign core_en      = (state_q == S_LAUNCH);
  assign o_div_ready  = (state_q == S_IDLE);
  assign o_div_valid  = (state_q == S_RESP);
  assign o_div_busy   = (state_q != S_IDLE);
  assign o_div_result = result_q;

  riscv_core_non_restoring #(
    .XLEN(XLEN)
  ) u_core (
    .clk       (i_non_restoring_clk),
    .rstn      (i_non_restoring_rstn),
    .en        (core_en),
    .dividend  (abs_a_q),
    .divisor   (abs_b_q),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

endmodule

// File: tb/tb_riscv_core_div_unit.sv
// tb/tb_riscv_core_div_unit.sv - scoreboard bench for the RV64M divide front-end
module tb_riscv_core_div_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_div_valid, i_div_word, i_div_flush, i_div_ready;
  logic [1:0]  i_div_op;
  logic [63:0] i_div_rs1, i_div_rs2;
  logic        o_div_ready, o_div_valid, o_div_busy;
  logic [63:0] o_div_result;

  int          vectors = 0;
  int          miscompares = 0;
  int          en_count = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_core_div_unit #(.XLEN(64)) dut (
    .i_non_restoring_clk  (clk),
    .i_non_restoring_rstn (rstn),
    .i_div_valid          (i_div_valid),
    .o_div_ready          (o_div_ready),
    .i_div_op             (i_div_op),
    .i_div_word           (i_div_word),
    .i_div_rs1            (i_div_rs1),
    .i_div_rs2            (i_div_rs2),
    .i_div_flush          (i_div_flush),
    .o_div_valid          (o_div_valid),
    .i_div_ready          (i_div_ready),
    .o_div_result         (o_div_result),
    .o_div_busy           (o_div_busy)
  );

  always @(posedge clk) if (dut.core_en) en_count <= en_count + 1;

  function automatic logic [63:0] ref_div(logic [1:0] op, logic word, logic [63:0] a, logic [63:0] b);
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa64, sb64;
    logic [31:0] r32;
    logic [63:0] r64;
    sa32 = a[31:0]; sb32 = b[31:0];
    sa64 = a;       sb64 = b;
    if (word) begin
      case (op)
        2'b00:   r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : (sa32 == 32'sh8000_0000 && sb32 == -32'sd1) ? a[31:0] : 32'(sa32 / sb32);
        2'b01:   r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
        2'b10:   r32 = (b[31:0] == 0) ? a[31:0] : (sa32 == 32'sh8000_0000 && sb32 == -32'sd1) ? 32'h0 : 32'(sa32 % sb32);
        default: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (op)
      2'b00:   r64 = (b == 0) ? '1 : (a == 64'h8000_0000_0000_0000 && b == '1) ? a : 64'(sa64 / sb64);
      2'b01:   r64 = (b == 0) ? '1 : a / b;
      2'b10:   r64 = (b == 0) ? a : (a == 64'h8000_0000_0000_0000 && b == '1) ? 64'h0 : 64'(sa64 % sb64);
      default: r64 = (b == 0) ? a : a % b;
    endcase
    return r64;
  endfunction

  // Issues one request, waits (bounded) for the result, optionally stalls the handshake.
  task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b,
                        input int stall, output logic [63:0] res, output int lat,
                        output bit ready_low, output bit stable);
    res = '0; lat = 0; ready_low = 1'b1; stable = 1'b1;
    @(negedge clk);
    i_div_valid = 1'b1; i_div_op = op; i_div_word = word; i_div_rs1 = a; i_div_rs2 = b;
    @(posedge clk);
    while (lat < 200) begin
      @(negedge clk);
      i_div_valid = 1'b0;
      lat++;
      if (o_div_valid) break;
      if (o_div_ready) ready_low = 1'b0;
    end
    if (o_div_valid) begin
      res = o_div_result;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!o_div_valid || o_div_result !== res || o_div_ready) stable = 1'b0;
      end
      i_div_ready = 1'b1;
      @(posedge clk);
      #1 i_div_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_div_valid, o_div_ready, o_div_busy} !== 3'b010 || o_div_result !== 64'h0) begin
      miscompares++;
      $display("FAIL reset: valid/ready/busy=%b result=%h, expected 010 and 0",
               {o_div_valid, o_div_ready, o_div_busy}, o_div_result);
    end
    rstn = 1'b1;
  endtask

  task automatic test_ops(input string tag);
    logic [1:0]  ops[10]; logic words[10]; logic [63:0] as[10]; logic [63:0] bs[10]; int lats[10];
    logic [63:0] res, exp; int lat, e0; bit rl, st;
    ops   = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00};
    words = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    as    = '{64'd100, 64'd100, -64'sd100, -64'sd100, 64'd100, 64'd5, 64'd5,
              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000};
    bs    = '{64'd7, 64'd7, 64'd7, 64'd7, -64'sd7, 64'd0, 64'd0, '1, '1, '1};
    lats  = '{66, 66, 66, 66, 66, 1, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(ref_div(ops[i], words[i], as[i], bs[i]));
      e0 = en_count;
      run_op(ops[i], words[i], as[i], bs[i], 0, res, lat, rl, st);
      exp = exp_q.pop_front();
      vectors++;
      if (res !== exp) begin
        miscompares++;
        $display("FAIL %s[%0d] result: got %h expected %h", tag, i, res, exp);
      end
      vectors++;
      if (lat !== lats[i]) begin
        miscompares++;
        $display("FAIL %s[%0d] latency: got %0d expected %0d", tag, i, lat, lats[i]);
      end
      vectors++;
      if (!rl) begin
        miscompares++;
        $display("FAIL %s[%0d] ready_low: ready seen high while busy, expected low", tag, i);
      end
      vectors++;
      if (en_count - e0 !== ((lats[i] == 1) ? 0 : 1)) begin
        miscompares++;
        $display("FAIL %s[%0d] core_en pulses: got %0d expected %0d", tag, i, en_count - e0, (lats[i] == 1) ? 0 : 1);
      end
    end
  endtask

  task automatic test_word;
    logic [1:0] ops[3]; logic [63:0] as[3]; logic [63:0] bs[3];
    logic [63:0] res, exp; int lat; bit rl, st;
    ops = '{2'b01, 2'b10, 2'b00};
    as  = '{64'hFFFF_FFFF_0000_0010, -64'sd7, 64'h0000_0000_7FFF_FFFF};
    bs  = '{64'd2, 64'd2, 64'd1};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ref_div(ops[i], 1'b1, as[i], bs[i]));
      run_op(ops[i], 1'b1, as[i], bs[i], 0, res, lat, rl, st);
      exp = exp_q.pop_front();
      vectors++;
      if (res !== exp || lat !== 66) begin
        miscompares++;
        $display("FAIL word[%0d]: got %h at cycle %0d expected %h at cycle 66", i, res, lat, exp);
      end
    end
  endtask

  task automatic test_flush;
    bit drain_bad = 1'b0, valid_seen = 1'b0;
    logic [63:0] res, exp; int lat; bit rl, st;
    @(negedge clk);
    i_div_valid = 1'b1; i_div_op = 2'b01; i_div_word = 1'b0; i_div_rs1 = 64'd100; i_div_rs2 = 64'd7;
    @(posedge clk);
    for (int cyc = 1; cyc <= 66; cyc++) begin
      @(negedge clk);
      i_div_valid = 1'b0;
      i_div_flush = (cyc == 20);
      if (o_div_valid) valid_seen = 1'b1;
      if (cyc >= 21 && cyc <= 65 && o_div_ready) drain_bad = 1'b1;
      if (cyc == 66) begin
        vectors++;
        if (o_div_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL flush_ready_return: ready=%b at cycle 66 expected 1", o_div_ready);
        end
      end
    end
    vectors++;
    if (drain_bad) begin
      miscompares++;
      $display("FAIL flush_drain_ready: ready high during drain, expected low");
    end
    vectors++;
    if (valid_seen) begin
      miscompares++;
      $display("FAIL flush_no_valid: valid seen after flush, expected none");
    end
    exp_q.push_back(ref_div(2'b01, 1'b0, 64'd9, 64'd3));
    run_op(2'b01, 1'b0, 64'd9, 64'd3, 0, res, lat, rl, st);
    exp = exp_q.pop_front();
    vectors++;
    if (res !== exp || lat !== 66) begin
      miscompares++;
      $display("FAIL after_flush: got %h at cycle %0d expected %h at cycle 66", res, lat, exp);
    end
  endtask

  task automatic test_stall;
    logic [63:0] res, exp; int lat; bit rl, st;
    exp_q.push_back(ref_div(2'b00, 1'b0, -64'sd100, 64'd7));
    run_op(2'b00, 1'b0, -64'sd100, 64'd7, 10, res, lat, rl, st);
    exp = exp_q.pop_front();
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL stall_result: got %h expected %h", res, exp);
    end
    vectors++;
    if (!st) begin
      miscompares++;
      $display("FAIL stall_stable: result/valid changed while consumer stalled, expected held");
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] op; logic word; logic [63:0] a, b, res, exp; int lat; bit rl, st;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      word = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = (i % 3 == 0) ? 64'($urandom_range(1, 300)) : {$urandom, $urandom} >> $urandom_range(0, 40);
      if (i % 4 == 1) a = -a;
      exp_q.push_back(ref_div(op, word, a, b));
      run_op(op, word, a, b, 0, res, lat, rl, st);
      exp = exp_q.pop_front();
      vectors++;
      if (res !== exp) begin
        miscompares++;
        $display("FAIL b2b[%0d] op=%0d w=%0d a=%h b=%h: got %h expected %h", i, op, word, a, b, res, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] res, exp; int lat; bit rl, st;
    @(negedge clk);
    i_div_valid = 1'b1; i_div_op = 2'b01; i_div_word = 1'b0; i_div_rs1 = 64'd1000; i_div_rs2 = 64'd3;
    @(posedge clk);
    repeat (30) @(negedge clk);
    i_div_valid = 1'b0;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({o_div_valid, o_div_ready, o_div_busy} !== 3'b010 || o_div_result !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_mid: valid/ready/busy=%b result=%h, expected 010 and 0",
               {o_div_valid, o_div_ready, o_div_busy}, o_div_result);
    end
    @(negedge clk);
    rstn = 1'b1;
    exp_q.push_back(ref_div(2'b11, 1'b0, 64'd1000, 64'd7));
    run_op(2'b11, 1'b0, 64'd1000, 64'd7, 0, res, lat, rl, st);
    exp = exp_q.pop_front();
    vectors++;
    if (res !== exp || lat !== 66) begin
      miscompares++;
      $display("FAIL after_reset_mid: got %h at cycle %0d expected %h at cycle 66", res, lat, exp);
    end
  endtask

  initial begin
    i_div_valid = 1'b0; i_div_op = 2'b00; i_div_word = 1'b0; i_div_rs1 = '0; i_div_rs2 = '0;
    i_div_flush = 1'b0; i_div_ready = 1'b0;
    test_reset();
    test_ops("ops");
    test_word();
    test_flush();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
